// File: rtl/accel_msg_loader.sv
// accel_msg_loader: SHA-256 front end. Snoops CPU word writes into a 17-word
// window, stages sixteen 32-bit words, and on a CPU launch command hands the
// 512-bit block to the hash core over a valid/ready handshake. Staging and
// output register are separate, so the next block can be filled while the
// previous one waits for the core.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   mem_listen_en      CPU write strobe (one word per cycle)
//   mem_listen_addr    CPU word address
//   mem_listen_data    CPU write data
//   blk_valid          output block valid
//   blk_data           512-bit block, word 0 at [511:480], word 15 at [31:0]
//   blk_ready          hash core accepts the block
//   word_cnt           popcount of the staging fill mask (0..16)
//   err_incomplete     sticky: launch with an incomplete mask
//   err_overrun        sticky: launch while the output was held and not draining
//
// Window map (word addresses relative to BASE_ADDR):
//   +0..+15  staging slots
//   +16      CTRL: bit0 launch, bit1 clear mask, bit2 clear sticky errors

module accel_msg_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_listen_en,
  input  logic [15:0]  mem_listen_addr,
  input  logic [31:0]  mem_listen_data,
  output logic         blk_valid,
  output logic [511:0] blk_data,
  input  logic         blk_ready,
  output logic [4:0]   word_cnt,
  output logic         err_incomplete,
  output logic         err_overrun
);

  localparam int unsigned NumWords = 16;

  typedef enum logic [0:0] {
    StOutEmpty,
    StOutFull
  } out_state_e;

  out_state_e   state_q, state_d;
  logic [511:0] stage_q, stage_d;
  logic [511:0] blk_q, blk_d;
  logic [15:0]  mask_q, mask_d;
  logic         err_inc_q, err_inc_d;
  logic         err_ovr_q, err_ovr_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // Modular subtraction: addresses below BASE_ADDR wrap to large offsets and
  // therefore fall outside the window without a separate lower-bound compare.
  logic [15:0] offset;
  logic [3:0]  slot_idx;
  logic        slot_wr;
  logic        ctrl_wr;

  assign offset   = mem_listen_addr - BASE_ADDR;
  assign slot_idx = offset[3:0];
  assign slot_wr  = mem_listen_en && (offset < 16'd16);
  assign ctrl_wr  = mem_listen_en && (offset == 16'd16);

  logic launch_req;
  logic clr_mask;
  logic clr_err;
  logic launch_try;
  logic mask_full;
  logic out_free;
  logic launch_ok;

  assign launch_req = ctrl_wr && mem_listen_data[0];
  assign clr_mask   = ctrl_wr && mem_listen_data[1];
  assign clr_err    = ctrl_wr && mem_listen_data[2];

  // A launch paired with a mask clear is dropped entirely: no copy, no error.
  assign launch_try = launch_req && !clr_mask;
  assign mask_full  = (mask_q == 16'hFFFF);
  // Output can take a new block if empty or draining this very cycle.
  assign out_free   = (state_q == StOutEmpty) || blk_ready;
  assign launch_ok  = launch_try && mask_full && out_free;

  // ---------------------------------------------------------------------------
  // Staging buffer and fill mask
  // ---------------------------------------------------------------------------
  always_comb begin
    stage_d = stage_q;
    for (int i = 0; i < NumWords; i++) begin
      if (slot_wr && (slot_idx == 4'(i))) begin
        stage_d[(NumWords - 1 - i) * 32 +: 32] = mem_listen_data;
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (slot_wr) begin
      mask_d[slot_idx] = 1'b1;
    end
    // Staging data is kept after a launch or clear; only the mask marks it stale.
    if (launch_ok || clr_mask) begin
      mask_d = '0;
    end
  end

  always_comb begin
    word_cnt = '0;
    for (int i = 0; i < NumWords; i++) begin
      word_cnt = word_cnt + 5'(mask_q[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky errors (clear beats a same-cycle set)
  // ---------------------------------------------------------------------------
  always_comb begin
    err_inc_d = err_inc_q;
    err_ovr_d = err_ovr_q;
    if (launch_try && !mask_full) begin
      err_inc_d = 1'b1;
    end
    if (launch_try && !out_free) begin
      err_ovr_d = 1'b1;
    end
    if (clr_err) begin
      err_inc_d = 1'b0;
      err_ovr_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    unique case (state_q)
      StOutEmpty: begin
        if (launch_ok) begin
          state_d = StOutFull;
          blk_d   = stage_q;
        end
      end
      StOutFull: begin
        if (launch_ok) begin
          // Transfer and reload at the same edge: stay full with the new block.
          blk_d = stage_q;
        end else if (blk_ready) begin
          state_d = StOutEmpty;
        end
      end
      default: begin
        state_d = StOutEmpty;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StOutEmpty;
      stage_q   <= '0;
      blk_q     <= '0;
      mask_q    <= '0;
      err_inc_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      blk_q     <= blk_d;
      mask_q    <= mask_d;
      err_inc_q <= err_inc_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  // blk_q is reset, so blk_data reads 0 as soon as rst asserts.
  assign blk_valid      = (state_q == StOutFull);
  assign blk_data       = blk_q;
  assign err_incomplete = err_inc_q;
  assign err_overrun    = err_ovr_q;

endmodule

// File: tb/tb_accel_msg_loader.sv
// Directed, table-driven bench for accel_msg_loader. Each record drives one
// cycle of inputs and lists the outputs expected just after the clock edge.
module tb_accel_msg_loader;

  localparam logic [15:0] Base = 16'h0100;
  localparam logic [15:0] Ctrl = 16'h0110;

  logic         clk;
  logic         rst;
  logic         mem_listen_en;
  logic [15:0]  mem_listen_addr;
  logic [31:0]  mem_listen_data;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_ready;
  logic [4:0]   word_cnt;
  logic         err_incomplete;
  logic         err_overrun;

  accel_msg_loader #(
    .BASE_ADDR(Base)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_listen_en  (mem_listen_en),
    .mem_listen_addr(mem_listen_addr),
    .mem_listen_data(mem_listen_data),
    .blk_valid      (blk_valid),
    .blk_data       (blk_data),
    .blk_ready      (blk_ready),
    .word_cnt       (word_cnt),
    .err_incomplete (err_incomplete),
    .err_overrun    (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [15:0]  addr;
    logic [31:0]  data;
    logic         ready;
    logic         exp_valid;
    logic [4:0]   exp_cnt;
    logic         exp_inc;
    logic         exp_ovr;
    logic         chk_blk;
    logic [511:0] exp_blk;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  task automatic add(input logic en, input logic [15:0] addr, input logic [31:0] data,
                     input logic ready, input logic ev, input int ec, input logic ei,
                     input logic eo, input logic cb, input logic [511:0] eb);
    vec_t v;
    v.en = en; v.addr = addr; v.data = data; v.ready = ready;
    v.exp_valid = ev; v.exp_cnt = 5'(ec); v.exp_inc = ei; v.exp_ovr = eo;
    v.chk_blk = cb; v.exp_blk = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [15:0] addr, input logic [31:0] data,
                       input logic ready);
    @(negedge clk);
    mem_listen_en   = en;
    mem_listen_addr = addr;
    mem_listen_data = data;
    blk_ready       = ready;
    @(posedge clk);
    #1;
  endtask

  logic [511:0] blk_a, blk_b, blk_c, blk_d;
  int n;

  initial begin
    n_vec = 0;
    n_bad = 0;
    mem_listen_en   = 1'b0;
    mem_listen_addr = '0;
    mem_listen_data = '0;
    blk_ready       = 1'b0;
    rst             = 1'b1;

    for (int k = 0; k < 16; k++) begin
      blk_a[(15 - k) * 32 +: 32] = 32'(k);
      blk_b[(15 - k) * 32 +: 32] = 32'hB0B0_0000 + 32'(k);
      blk_c[(15 - k) * 32 +: 32] = 32'hC000_0000 + 32'(k);
      blk_d[(15 - k) * 32 +: 32] = (k == 3) ? 32'h2 : 32'hD000_0000 + 32'(k);
    end

    // Basic fill and drain
    for (int i = 0; i < 16; i++) add(1, Base + 16'(i), 32'(i), 0, 0, i + 1, 0, 0, 0, '0);
    add(1, Ctrl, 32'h1, 0, 1, 0, 0, 0, 1, blk_a);
    add(0, 16'h0, 32'h0, 1, 0, 0, 0, 0, 0, '0);

    // Incomplete launch, then completed launch, then error clear
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (i != 7) begin
        n++;
        add(1, Base + 16'(i), 32'hC000_0000 + 32'(i), 0, 0, n, 0, 0, 0, '0);
      end
    end
    add(1, Ctrl, 32'h1, 0, 0, 15, 1, 0, 0, '0);
    add(1, Base + 16'd7, 32'hC000_0007, 0, 0, 16, 1, 0, 0, '0);
    add(1, Ctrl, 32'h1, 0, 1, 0, 1, 0, 1, blk_c);
    add(1, Ctrl, 32'h4, 0, 1, 0, 0, 0, 1, blk_c);

    // Overrun while C is held, then drain-and-relaunch in one cycle
    for (int i = 0; i < 16; i++)
      add(1, Base + 16'(i), 32'hB0B0_0000 + 32'(i), 0, 1, i + 1, 0, 0, 1, blk_c);
    add(1, Ctrl, 32'h1, 0, 1, 16, 0, 1, 1, blk_c);
    add(1, Ctrl, 32'h1, 1, 1, 0, 0, 1, 1, blk_b);
    add(0, 16'h0, 32'h0, 1, 0, 0, 0, 1, 0, '0);

    // Window decode and slot overwrite
    add(1, Ctrl, 32'h4, 0, 0, 0, 0, 0, 0, '0);
    add(1, Base - 16'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, '0);
    add(1, Base + 16'd17, 32'h0000_0007, 0, 0, 0, 0, 0, 0, '0);
    add(0, Base, 32'h1234_5678, 0, 0, 0, 0, 0, 0, '0);
    add(1, Base + 16'd3, 32'h1, 0, 0, 1, 0, 0, 0, '0);
    add(1, Base + 16'd3, 32'h2, 0, 0, 1, 0, 0, 0, '0);
    n = 1;
    for (int i = 0; i < 16; i++) begin
      if (i != 3) begin
        n++;
        add(1, Base + 16'(i), 32'hD000_0000 + 32'(i), 0, 0, n, 0, 0, 0, '0);
      end
    end
    add(1, Ctrl, 32'h1, 0, 1, 0, 0, 0, 1, blk_d);
    add(0, 16'h0, 32'h0, 1, 0, 0, 0, 0, 0, '0);

    // Clear wins over launch; error clear wins over error set
    for (int i = 0; i < 16; i++)
      add(1, Base + 16'(i), 32'hE000_0000 + 32'(i), 0, 0, i + 1, 0, 0, 0, '0);
    add(1, Ctrl, 32'h3, 0, 0, 0, 0, 0, 0, '0);
    add(1, Ctrl, 32'h1, 0, 0, 0, 1, 0, 0, '0);
    add(1, Ctrl, 32'h5, 0, 0, 0, 0, 0, 0, '0);

    // Reset state
    #3;
    check("reset blk_valid", 512'(blk_valid), 512'(0));
    check("reset blk_data", blk_data, 512'(0));
    check("reset word_cnt", 512'(word_cnt), 512'(0));
    check("reset err_incomplete", 512'(err_incomplete), 512'(0));
    check("reset err_overrun", 512'(err_overrun), 512'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].ready);
      check($sformatf("v%0d blk_valid", i), 512'(blk_valid), 512'(vecs[i].exp_valid));
      check($sformatf("v%0d word_cnt", i), 512'(word_cnt), 512'(vecs[i].exp_cnt));
      check($sformatf("v%0d err_incomplete", i), 512'(err_incomplete), 512'(vecs[i].exp_inc));
      check($sformatf("v%0d err_overrun", i), 512'(err_overrun), 512'(vecs[i].exp_ovr));
      if (vecs[i].chk_blk) check($sformatf("v%0d blk_data", i), blk_data, vecs[i].exp_blk);
    end

    // Async reset while a block is held
    for (int i = 0; i < 16; i++) drive(1, Base + 16'(i), 32'hF000_0000 + 32'(i), 0);
    drive(1, Ctrl, 32'h1, 0);
    check("pre-reset blk_valid", 512'(blk_valid), 512'(1));
    drive(1, Ctrl, 32'h1, 0);
    check("pre-reset err_overrun", 512'(err_overrun), 512'(1));
    @(negedge clk);
    mem_listen_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async rst blk_valid", 512'(blk_valid), 512'(0));
    check("async rst blk_data", blk_data, 512'(0));
    check("async rst word_cnt", 512'(word_cnt), 512'(0));
    check("async rst err_overrun", 512'(err_overrun), 512'(0));
    check("async rst err_incomplete", 512'(err_incomplete), 512'(0));
    #1 rst = 1'b0;
    drive(0, 16'h0, 32'h0, 0);
    check("post-rst blk_valid", 512'(blk_valid), 512'(0));
    // Mask was dropped by reset, so a launch must be rejected as incomplete.
    drive(1, Ctrl, 32'h1, 0);
    check("post-rst launch blk_valid", 512'(blk_valid), 512'(0));
    check("post-rst launch err_incomplete", 512'(err_incomplete), 512'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/accel_msg_loader.md
# accel_msg_loader

Front-end stage of the SHA-256 accelerator block. It snoops the CPU memory-write listen bus (`mem_listen_*`) for a fixed address window and stages sixteen 32-bit words into a 512-bit message block. On a CPU launch command it hands the block to the downstream hash core over a valid/ready handshake. Staging and output are double-buffered, so the CPU can fill the next block while the previous one waits for the core.

## Interface
- `BASE_ADDR`, default 16'h0100: first word address of the window. The window is word-addressed.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_listen_en`  in  1  CPU write strobe, one word per cycle.
- `mem_listen_addr`  in  16  CPU write word address.
- `mem_listen_data`  in  32  CPU write data.
- `blk_valid`  out  1  output block is valid.
- `blk_data`  out  512  message block.
  - Word 0 is at [511:480].
  - Word 15 is at [31:0].
- `blk_ready`  in  1  hash core accepts the block.
- `word_cnt`  out  5  number of distinct staging slots written since the last clear or launch (0..16).
- `err_incomplete`  out  1  sticky: a launch arrived with `word_cnt` < 16.
- `err_overrun`  out  1  sticky: a launch arrived while the output register was occupied and not draining.

## Operation
- **Address decode** (only when `mem_listen_en`=1):
  - `BASE_ADDR`+0 .. +15: write the staging slot `addr-BASE_ADDR` and set that slot's bit in the 16-bit fill mask. Rewriting a slot overwrites the data; the mask is unchanged.
  - `BASE_ADDR`+16 (CTRL):
    - `data[0]`=1: launch.
    - `data[1]`=1: clear the staging mask.
    - `data[2]`=1: clear both sticky errors.
    - When bits 0 and 1 are both set, clear wins and no launch occurs.
  - All other addresses: ignored.
- `word_cnt` is the popcount of the fill mask.
- **Output FSM states:**
  - OUT_EMPTY: `blk_valid`=0.
  - OUT_FULL: `blk_valid`=1.
- **Launch accepted** when all three hold:
  - mask == 16'hFFFF;
  - state is OUT_EMPTY, or OUT_FULL with `blk_ready`=1 in the same cycle;
  - bit 1 is not set.
- **On an accepted launch:**
  - Copy staging into the output register.
  - Clear the mask. Staging data is retained but is treated as stale.
  - Go to OUT_FULL.
- **Rejected launch:**
  - Mask incomplete: set `err_incomplete`. Nothing else changes.
  - Mask complete, output occupied and `blk_ready`=0: set `err_overrun`. Staging and mask are kept so the CPU can retry.
  - If both conditions apply, set both errors.
- **Handshake:**
  - A transfer happens on a cycle where `blk_valid`=1 and `blk_ready`=1.
  - Without a simultaneous accepted launch, the FSM goes to OUT_EMPTY.
  - `blk_data` stays stable while `blk_valid`=1 and no transfer has occurred.
- Error clear (CTRL `data[2]`) has priority over an error set in the same cycle.

## Timing
- Reset values (asynchronous on `rst`):
  - `blk_valid`=0, `blk_data`=0, `word_cnt`=0, `err_incomplete`=0, `err_overrun`=0.
  - Mask = 0, staging = 0, state = OUT_EMPTY.
- Assertion of `rst` mid-fill or mid-handshake drops the block immediately. Nothing is replayed after release.
- Slot write at edge N: `word_cnt` reflects it after edge N.
- Launch written at edge N: `blk_valid`=1 and `blk_data` valid after edge N (one-cycle latency). `word_cnt`=0 after edge N.
- Transfer at edge N without a launch: `blk_valid`=0 after edge N.
- Transfer and launch at the same edge N: `blk_valid` stays 1 and `blk_data` holds the new block after edge N.
- Error flags update at the edge of the offending CTRL write.
- Maximum throughput is one block per 17 CPU write cycles.

## Test plan
- **Basic fill and drain:**
  - Stimulus: write words 0..15 with data 32'h0000_0000+i, then CTRL=1, with `blk_ready`=0.
  - Required: after the launch edge, `blk_valid`=1, `blk_data[511:480]`=0, `blk_data[31:0]`=15, `word_cnt`=0.
  - Then raise `blk_ready` for 1 cycle: `blk_valid`=0 next cycle.
- **Incomplete launch:**
  - Stimulus: write 15 words (skip slot 7), then CTRL=1.
  - Required: `blk_valid` stays 0, `err_incomplete`=1, `word_cnt`=15.
  - Then write slot 7 and CTRL=1: launch accepted.
  - Then CTRL=4: `err_incomplete`=0.
- **Overrun and retry:**
  - Stimulus: with block A held (`blk_ready`=0), fill block B (all words 32'hB0B0_0000+i) and launch.
  - Required: `err_overrun`=1, `blk_data` still equals A, `word_cnt`=16.
  - Then raise `blk_ready` and relaunch in the same cycle: `blk_valid` stays 1 and `blk_data` equals B.
- **Window decode and overwrite:**
  - Writes to `BASE_ADDR`-1 and `BASE_ADDR`+17: no effect.
  - Writing slot 3 twice (values 32'h1 then 32'h2): `word_cnt`=1, and the launched block carries 32'h2 in [415:384].
- **Clear-wins and async reset:**
  - Full mask, then CTRL=3: mask cleared, no launch, no error.
  - Assert `rst` for a partial cycle while `blk_valid`=1: all outputs read 0 before the next clock edge.
